// File: rtl/pixel_proc_pkg.sv
// Shared constants for the pixel stream processor: image geometry defaults,
// mode encodings, FSM state type and the 3x3 Gaussian kernel.
package pixel_proc_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int IMG_W_DEF  = 32;
    localparam int IMG_H_DEF  = 32;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_INVERT = 2'b01;
    localparam logic [1:0] MODE_CONV   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Kernel weights sum to 16, so the normalising shift is 4.
    localparam int CONV_SHIFT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Weight of tap (3*row + col) in the kernel [1 2 1; 2 4 2; 1 2 1].
    function automatic logic [2:0] kernel_weight(input int tap);
        case (tap)
            4:          return 3'd4;
            1, 3, 5, 7: return 3'd2;
            default:    return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/conv3x3_window.sv
// 3x3 sliding window over a raster stream: two line buffers, a two-column
// window register plus the live column, the border flag and the kernel sum.
// The window centre sits IMG_W+1 pixels behind the pixel being accepted.
module conv3x3_window
    import pixel_proc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    localparam int COL_W = $clog2(IMG_W),
    localparam int ROW_W = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              advance,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic [COL_W-1:0]  col,
    input  logic [ROW_W-1:0]  row,
    output logic [DATA_W-1:0] filtered,
    output logic [DATA_W-1:0] centre,
    output logic              is_border
);

    localparam int SUM_W = DATA_W + CONV_SHIFT;

    // line_a holds the previous row, line_b the row before that.
    logic [DATA_W-1:0] line_a [IMG_W];
    logic [DATA_W-1:0] line_b [IMG_W];

    // Columns top..bottom: win_l = col-2, win_m = col-1, win_n = live column.
    logic [DATA_W-1:0] win_l [3];
    logic [DATA_W-1:0] win_m [3];
    logic [DATA_W-1:0] win_n [3];

    logic [SUM_W-1:0] sum;

    // Live column assembled from both line buffers and the incoming pixel.
    always_comb begin
        win_n[0] = line_b[col];
        win_n[1] = line_a[col];
        win_n[2] = pixel_in;
    end

    // Shift the line buffers and the window only when a pixel is accepted.
    always_ff @(posedge clk) begin
        if (advance) begin
            line_b[col] <= line_a[col];
            line_a[col] <= pixel_in;
            for (int i = 0; i < 3; i++) begin
                win_l[i] <= win_m[i];
                win_m[i] <= win_n[i];
            end
        end
    end

    // Weighted kernel sum; weights are 1/2/4 so the multiplies reduce to shifts.
    always_comb begin
        sum = '0;
        for (int y = 0; y < 3; y++) begin
            sum = sum
                + SUM_W'(win_l[y]) * SUM_W'(kernel_weight(3 * y))
                + SUM_W'(win_m[y]) * SUM_W'(kernel_weight(3 * y + 1))
                + SUM_W'(win_n[y]) * SUM_W'(kernel_weight(3 * y + 2));
        end
    end

    assign filtered = DATA_W'(sum >> CONV_SHIFT);
    assign centre   = win_m[1];

    // Centre is (row-1, col-1) modulo the frame: input col 0/1 maps to centre
    // col IMG_W-1/0, input row 0/1 maps to centre row IMG_H-1/0.
    assign is_border = (col < COL_W'(2)) || (row < ROW_W'(2));

endmodule

// File: rtl/pixel_stream_proc.sv
// Streaming pixel processor: bypass, invert or 3x3 Gaussian over a raster
// stream with valid/ready on both sides and one output register.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | stopped; counters, warm-up and VALID_OUT held clear
// ST_RUN  | processing with the mode latched on entry
module pixel_stream_proc
    import pixel_proc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              VALID_IN,
    output logic              READY_OUT,
    output logic [DATA_W-1:0] pixel_out,
    output logic              VALID_OUT,
    input  logic              READY_IN,
    input  logic [1:0]        mode,
    input  logic              start
);

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int WARM_W = $clog2(IMG_W + 2);
    localparam logic [WARM_W-1:0] WARM_LEN = WARM_W'(IMG_W + 1);

    state_t            state;
    state_t            state_next;
    logic [1:0]        mode_q;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [WARM_W-1:0] warm_cnt;
    logic              warm_done;
    logic              in_xfer;
    logic              out_xfer;
    logic              produce;
    logic [DATA_W-1:0] conv_filtered;
    logic [DATA_W-1:0] conv_centre;
    logic              conv_border;
    logic [DATA_W-1:0] result;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next state and input-side ready; mode 11 never accepts.
    always_comb begin
        state_next = state;
        READY_OUT  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!start) state_next = ST_IDLE;
                READY_OUT = (mode_q != MODE_RSVD) && (!VALID_OUT || READY_IN);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_xfer   = VALID_IN && READY_OUT;
    assign out_xfer  = VALID_OUT && READY_IN;
    assign warm_done = (warm_cnt == WARM_LEN);
    assign produce   = in_xfer && ((mode_q != MODE_CONV) || warm_done);

    // Mode is sampled only on the IDLE->RUN transition.
    always_ff @(posedge clk) begin
        if (!resetn)                      mode_q <= MODE_BYPASS;
        else if (state == ST_IDLE && start) mode_q <= mode;
    end

    // Raster position and warm-up tracking, cleared whenever stopped.
    always_ff @(posedge clk) begin
        if (!resetn || state_next == ST_IDLE) begin
            col      <= '0;
            row      <= '0;
            warm_cnt <= '0;
        end else if (in_xfer) begin
            if (col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
            if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
        end
    end

    conv3x3_window #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) u_window (
        .clk       (clk),
        .advance   (in_xfer),
        .pixel_in  (pixel_in),
        .col       (col),
        .row       (row),
        .filtered  (conv_filtered),
        .centre    (conv_centre),
        .is_border (conv_border)
    );

    // Select the processed value for the latched mode.
    always_comb begin
        result = pixel_in;
        case (mode_q)
            MODE_INVERT: result = ~pixel_in;
            MODE_CONV:   result = conv_border ? conv_centre : conv_filtered;
            default:     result = pixel_in;
        endcase
    end

    // Output register: a new result has priority over the drain of the old one.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            VALID_OUT <= 1'b0;
            pixel_out <= '0;
        end else if (state_next == ST_IDLE) begin
            VALID_OUT <= 1'b0;
        end else if (produce) begin
            VALID_OUT <= 1'b1;
            pixel_out <= result;
        end else if (out_xfer) begin
            VALID_OUT <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Randomised bench for pixel_stream_proc against a frame-level reference:
// accepted pixels are stored by frame position and each expected output is
// computed from the kernel definition at the lagged centre position.
module tb_pixel_stream_proc;
    import pixel_proc_pkg::*;

    localparam int W = 32;
    localparam int H = 32;
    localparam int N = W * H;
    localparam int MAX_CYCLES = 60000;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] pixel_in;
    logic       VALID_IN;
    logic       READY_OUT;
    logic [7:0] pixel_out;
    logic       VALID_OUT;
    logic       READY_IN;
    logic [1:0] mode;
    logic       start;

    always #5 clk = ~clk;

    pixel_stream_proc dut (
        .clk       (clk),
        .resetn    (resetn),
        .pixel_in  (pixel_in),
        .VALID_IN  (VALID_IN),
        .READY_OUT (READY_OUT),
        .pixel_out (pixel_out),
        .VALID_OUT (VALID_OUT),
        .READY_IN  (READY_IN),
        .mode      (mode),
        .start     (start)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cycles   = 0;
    bit         run_m    = 1'b0;
    logic [1:0] mode_m   = MODE_BYPASS;
    int         n_acc    = 0;
    logic [7:0] img [N];
    logic [7:0] exp_q [$];
    bit         was_stall = 1'b0;
    logic [7:0] held_pix  = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h at t=%0t", tag, got, want, $time);
    endtask

    // Expected output when accepted-pixel index k completes the window.
    function automatic logic [7:0] conv_ref(input int k);
        int c, r, x, s, wgt;
        logic [9:0] idx;
        c   = (k - (W + 1)) % N;
        r   = c / W;
        x   = c % W;
        idx = 10'(c);
        if (r == 0 || r == H - 1 || x == 0 || x == W - 1) return img[idx];
        s = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                wgt = (dy == 0 ? 2 : 1) * (dx == 0 ? 2 : 1);
                idx = 10'((r + dy) * W + x + dx);
                s   = s + wgt * int'(img[idx]);
            end
        end
        return 8'(s >> 4);
    endfunction

    task automatic accept(input logic [7:0] p);
        logic [7:0] inv;
        inv = ~p;
        img[10'(n_acc % N)] = p;
        case (mode_m)
            MODE_BYPASS: exp_q.push_back(p);
            MODE_INVERT: exp_q.push_back(inv);
            MODE_CONV:   if (n_acc >= W + 1) exp_q.push_back(conv_ref(n_acc));
            default:     ;
        endcase
        n_acc++;
    endtask

    // One clock: check outputs shortly after the falling edge, then update the
    // model with whatever the coming rising edge transfers.
    task automatic tick(output bit took);
        bit exp_ready, in_x, out_x;
        #1;
        exp_ready = run_m && (mode_m != MODE_RSVD) && (exp_q.size() == 0 || READY_IN);
        check_eq("ready_out", 32'(READY_OUT), 32'(exp_ready));
        check_eq("valid_out", 32'(VALID_OUT), 32'(exp_q.size() != 0));
        if (was_stall && VALID_OUT) check_eq("hold_stable", 32'(pixel_out), 32'(held_pix));
        was_stall = VALID_OUT && !READY_IN;
        held_pix  = pixel_out;
        out_x = VALID_OUT && READY_IN;
        in_x  = VALID_IN && READY_OUT;
        if (out_x && exp_q.size() > 0) check_eq("pixel_out", 32'(pixel_out), 32'(exp_q.pop_front()));
        if (in_x) accept(pixel_in);
        took = in_x;
        @(posedge clk);
        if (!resetn) begin
            run_m = 1'b0;
            exp_q.delete();
            n_acc = 0;
        end else begin
            if (!run_m && start) mode_m = mode;
            if (run_m && !start) begin
                exp_q.delete();
                n_acc = 0;
            end
            run_m = start;
        end
        cycles++;
        if (cycles > MAX_CYCLES) begin
            $display("FAIL timeout: cycles %0d exceeded limit %0d", cycles, MAX_CYCLES);
            $fatal(1, "cycle budget exhausted");
        end
        @(negedge clk);
    endtask

    task automatic idle_ticks(input int n);
        bit took;
        VALID_IN = 1'b0;
        READY_IN = 1'b1;
        for (int i = 0; i < n; i++) tick(took);
    endtask

    task automatic begin_run(input logic [1:0] m);
        bit took;
        mode     = m;
        start    = 1'b1;
        VALID_IN = 1'b0;
        READY_IN = 1'b1;
        tick(took);
    endtask

    task automatic end_run();
        idle_ticks(2);
        start = 1'b0;
        idle_ticks(2);
    endtask

    // kind: 0 ramp, 1 constant 0x40, 2 impulse at (5,5), 3 random.
    // The mode input is scrambled throughout to show it is ignored in RUN.
    task automatic stream(input int count, input int kind, input int p_valid, input int p_ready);
        int         sent;
        bit         took;
        logic [7:0] px;
        sent = 0;
        while (sent < count) begin
            case (kind)
                0:       px = 8'(sent);
                1:       px = 8'h40;
                2:       px = ((sent % N) == 5 * W + 5) ? 8'hFF : 8'h00;
                default: px = 8'($urandom);
            endcase
            pixel_in = px;
            VALID_IN = (int'($urandom_range(99)) < p_valid);
            READY_IN = (int'($urandom_range(99)) < p_ready);
            mode     = 2'($urandom_range(3));
            tick(took);
            if (took) sent++;
        end
        VALID_IN = 1'b0;
        READY_IN = 1'b1;
    endtask

    initial begin
        bit took;
        resetn   = 1'b0;
        start    = 1'b0;
        VALID_IN = 1'b0;
        READY_IN = 1'b1;
        pixel_in = 8'h00;
        mode     = MODE_BYPASS;
        @(negedge clk);
        idle_ticks(2);
        check_eq("reset_pixel_out", 32'(pixel_out), 32'h0);
        resetn = 1'b1;
        idle_ticks(2);

        // Bypass: ramp at full rate, then random handshakes.
        begin_run(MODE_BYPASS);
        stream(1024, 0, 100, 100);
        stream(300, 3, 70, 60);

        // Backpressure: output stalled five clocks with input pending.
        VALID_IN = 1'b1;
        READY_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pixel_in = 8'($urandom);
            tick(took);
        end
        READY_IN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pixel_in = 8'($urandom);
            tick(took);
        end
        READY_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pixel_in = 8'($urandom);
            tick(took);
        end
        end_run();

        // Invert.
        begin_run(MODE_INVERT);
        stream(1024, 0, 100, 100);
        stream(200, 3, 80, 80);
        end_run();

        // Reserved mode: nothing accepted, nothing produced.
        begin_run(MODE_RSVD);
        VALID_IN = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pixel_in = 8'($urandom);
            tick(took);
        end
        end_run();

        // Convolution: constant frame twice, impulse frame twice, random data.
        begin_run(MODE_CONV);
        stream(2 * N, 1, 90, 85);
        end_run();
        begin_run(MODE_CONV);
        stream(2 * N, 2, 100, 100);
        end_run();
        begin_run(MODE_CONV);
        stream(1500, 3, 75, 75);

        // Reset mid-frame with start held; run resumes in the new mode.
        mode     = MODE_INVERT;
        VALID_IN = 1'b1;
        resetn   = 1'b0;
        tick(took);
        tick(took);
        resetn   = 1'b1;
        VALID_IN = 1'b0;
        tick(took);
        stream(100, 3, 80, 80);
        end_run();

        // Restart convolution: warm-up must begin again from zero.
        begin_run(MODE_CONV);
        stream(200, 3, 80, 80);
        end_run();
        begin_run(MODE_CONV);
        stream(100, 1, 100, 100);
        end_run();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
